instr_fetch_seq: RTL and testbench

// - Fetch/sequencer stage upstream of the GPR/ALU execute block.
// - Holds the program memory and PC. Fetches 32-bit instruction words and issues them to execute as IR.
// - Decides the next PC from jump opcodes and the zero/sign/carry/overflow flags returned by execute.
// - Halts on the HALT opcode.

---
 rtl/instr_fetch_seq.sv | 105 ++++++++++
 tb/tb_instr_fetch_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: program memory, PC and issue sequencer feeding the execute stage; `INSTR_DELAY_EN adds post-issue idle cycles
module instr_fetch_seq #(
  parameter int AW = 4,
  parameter int EXEC_DELAY = 2
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          pm_we,
  input  logic [AW-1:0] pm_waddr,
  input  logic [31:0]   pm_wdata,
  output logic [31:0]   ir,
  output logic          ir_valid,
  input  logic          exec_ready,
  input  logic          zero_flag,
  input  logic          sign_flag,
  input  logic          carry_flag,
  input  logic          overflow_flag,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);
  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE,
`ifdef INSTR_DELAY_EN
    DELAY,
`endif
    NEXT, HALT
  } state_t;
  state_t state;
  logic [31:0] mem [2**AW];
  logic [4:0] op;
  logic take;
  logic idle;
`ifdef INSTR_DELAY_EN
  localparam int DW = EXEC_DELAY > 2 ? $clog2(EXEC_DELAY) : 1;
  logic [DW-1:0] cnt;
`else
  logic unused_delay;
  assign unused_delay = |EXEC_DELAY;
`endif
  always_comb begin
    op = ir[31:27];
    idle = state == IDLE || state == HALT;
    take = (op == 5'd12) ||
           (op == 5'd13 && carry_flag) || (op == 5'd14 && !carry_flag) ||
           (op == 5'd15 && sign_flag) || (op == 5'd16 && !sign_flag) ||
           (op == 5'd17 && zero_flag) || (op == 5'd18 && !zero_flag) ||
           (op == 5'd19 && overflow_flag) || (op == 5'd20 && !overflow_flag);
  end
  // Memory only loads while stopped, so a running program never sees its own words change
  always_ff @(posedge clk)
    if (pm_we && idle) mem[pm_waddr] <= pm_wdata;
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      ir_valid <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
`ifdef INSTR_DELAY_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          state <= FETCH;
          pc <= '0;
          busy <= 1'b1;
          halted <= 1'b0;
        end
        FETCH: begin
          ir <= mem[pc];
          ir_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (exec_ready) begin
          ir_valid <= 1'b0;
`ifdef INSTR_DELAY_EN
          state <= (EXEC_DELAY == 0) ? NEXT : DELAY;
          cnt <= DW'(EXEC_DELAY - 1);
`else
          state <= NEXT;
`endif
        end
`ifdef INSTR_DELAY_EN
        DELAY: begin
          state <= (cnt == '0) ? NEXT : DELAY;
          cnt <= cnt - 1'b1;
        end
`endif
        NEXT: if (op == 5'd27) begin
          state <= HALT;
          busy <= 1'b0;
          halted <= 1'b1;
        end else begin
          pc <= take ? ir[AW-1:0] : pc + 1'b1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: randomized scoreboard bench for instr_fetch_seq against a program-level execution model
module tb_instr_fetch_seq;
  localparam int LIMIT = 24;
`ifdef INSTR_DELAY_EN
  localparam int SP = 5;
`else
  localparam int SP = 3;
`endif
  typedef struct { logic [31:0] w; logic [3:0] p; } ent_t;
  logic clk = 0, sys_rst, start, pm_we, exec_ready;
  logic [3:0] pm_waddr;
  logic [31:0] pm_wdata, ir;
  logic ir_valid, zero_flag, sign_flag, carry_flag, overflow_flag, busy, halted;
  logic [3:0] pc;
  logic [31:0] prog [16];
  logic [31:0] mmem [16];
  ent_t exp_q[$];
  int acc_q[$];
  int total = 0, bad = 0, cyc = 0, mode = 0, sc = 0, exp_pc = 0;
  bit hold = 0, exp_halt = 0;

  instr_fetch_seq dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .pm_we(pm_we), .pm_waddr(pm_waddr),
    .pm_wdata(pm_wdata), .ir(ir), .ir_valid(ir_valid), .exec_ready(exec_ready),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .pc(pc), .busy(busy), .halted(halted)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  initial begin
    exec_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      if (hold) exec_ready = 0;
      else if (mode == 0) exec_ready = 1;
      else if (mode == 1) exec_ready = ($urandom % 3) != 0;
      else if (ir_valid && sc < 4) begin exec_ready = 0; sc++; end
      else begin exec_ready = 1; sc = 0; end
    end
  end

  always @(negedge clk) begin
    if (ir_valid && exec_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue actual ir=%h pc=%0d required none", ir, pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("issue_ir", ir, e.w);
        chk("issue_pc", 32'(pc), 32'(e.p));
        acc_q.push_back(cyc + 1);
      end
    end else if (ir_valid && exp_q.size() > 0) begin
      chk("stall_ir", ir, exp_q[0].w);
      chk("stall_pc", 32'(pc), 32'(exp_q[0].p));
    end
  end

  task automatic model(input logic [3:0] fl);
    int p = 0;
    exp_q.delete();
    exp_halt = 0;
    for (int n = 0; n < LIMIT; n++) begin
      logic [31:0] w;
      int op;
      bit tk;
      w = mmem[p];
      exp_q.push_back('{w, 4'(p)});
      op = int'(w[31:27]);
      if (op == 27) begin
        exp_halt = 1;
        exp_pc = p;
        break;
      end
      case (op)
        12: tk = 1;
        13: tk = fl[2];
        14: tk = !fl[2];
        15: tk = fl[1];
        16: tk = !fl[1];
        17: tk = fl[0];
        18: tk = !fl[0];
        19: tk = fl[3];
        20: tk = !fl[3];
        default: tk = 0;
      endcase
      p = tk ? int'(w[3:0]) : (p + 1) % 16;
    end
  endtask

  task automatic run(input bit reload, input bit wstart, input int md, input bit nz, input logic [3:0] fl);
    int t0 = 0;
    bit done = 0;
    if (reload) mmem = prog;
    model(fl);
    {overflow_flag, carry_flag, sign_flag, zero_flag} = fl;
    mode = md;
    acc_q.delete();
    if (reload)
      for (int a = 15; a >= 0; a--) begin
        @(posedge clk); #1;
        pm_we = 1;
        pm_waddr = 4'(a);
        pm_wdata = mmem[a];
        start = wstart && a == 0;
        if (start) t0 = cyc + 1;
      end
    if (!reload || !wstart) begin
      @(posedge clk); #1;
      pm_we = 0;
      start = 1;
      t0 = cyc + 1;
    end
    @(posedge clk); #1;
    pm_we = 0;
    start = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_halt ? halted : exp_q.size() == 0) done = 1;
      else begin
        @(posedge clk); #1;
        pm_we = nz && busy && ($urandom % 2 == 0);
        pm_waddr = 4'($urandom);
        pm_wdata = $urandom;
        start = nz && busy && ($urandom % 4 == 0);
      end
    end
    pm_we = 0;
    start = 0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL run_timeout actual halted=%b left=%0d required completion", halted, exp_q.size());
    end else if (exp_halt) begin
      chk("halted", 32'(halted), 1);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_valid", 32'(ir_valid), 0);
      chk("halt_pc", 32'(pc), 32'(exp_pc));
      chk("halt_ir", ir, mmem[exp_pc]);
      chk("drained", exp_q.size(), 0);
      if (md == 0)
        for (int k = 0; k < acc_q.size(); k++) chk("spacing", acc_q[k] - t0, 2 + k * SP);
    end else begin
      hold = 1;
      for (int i = 0; i < 50 && !ir_valid; i++) begin @(posedge clk); #1; end
      chk("pre_rst_valid", 32'(ir_valid), 1);
      sys_rst = 1;
      @(posedge clk); #1;
      sys_rst = 0;
      chk("rst_ir", ir, 0);
      chk("rst_valid", 32'(ir_valid), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_halted", 32'(halted), 0);
      hold = 0;
    end
  endtask

  task automatic gen_prog();
    for (int a = 0; a < 16; a++) begin
      int r = $urandom % 10;
      int op = r < 6 ? 12 + $urandom % 9 : r == 6 ? 27 : $urandom % 32;
      prog[a] = {5'(op), 23'($urandom), 4'($urandom)};
    end
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 16; a++) prog[a] = 32'h0000_0000;
  endtask

  initial begin
    sys_rst = 1; start = 0; pm_we = 0; pm_waddr = 0; pm_wdata = 0;
    {overflow_flag, carry_flag, sign_flag, zero_flag} = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    sys_rst = 0;
    chk("reset_ir", ir, 0);
    chk("reset_valid", 32'(ir_valid), 0);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_halted", 32'(halted), 0);
    clear_prog();
    prog[0] = 32'h0012_3400;
    prog[1] = (32'd1 << 27) | 32'h0000_0567;
    prog[2] = 32'd27 << 27;
    run(1, 0, 0, 0, 4'b0000);
    run(0, 0, 2, 0, 4'b0000);
    run(0, 0, 0, 1, 4'b0000);
    run(0, 0, 0, 0, 4'b0000);
    clear_prog();
    prog[0] = (32'd17 << 27) | 32'd5;
    prog[1] = 32'd27 << 27;
    prog[5] = 32'd27 << 27;
    run(1, 1, 0, 0, 4'b0001);
    run(0, 0, 0, 0, 4'b0000);
    clear_prog();
    prog[0] = (32'd13 << 27) | 32'd9;
    prog[1] = 32'd27 << 27;
    prog[9] = 32'd27 << 27;
    run(1, 0, 0, 0, 4'b0100);
    prog[0] = (32'd14 << 27) | 32'd9;
    run(1, 0, 1, 0, 4'b0100);
    clear_prog();
    prog[0] = (32'd12 << 27) | 32'd13;
    prog[13] = 32'h0000_0013;
    prog[14] = 32'h0800_0014;
    prog[15] = 32'h1000_0015;
    run(1, 0, 0, 1, 4'b0000);
    run(0, 0, 1, 0, 4'b1111);
    for (int i = 0; i < 30; i++) begin
      bit rl = (i % 3) != 2;
      if (rl) gen_prog();
      run(rl, 1'($urandom), int'($urandom % 3), 1'($urandom), 4'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
